// File: rtl/systolic_skew_feeder.sv
// Left-edge feeder for the systolic array: takes one ROWS-wide activation vector per
// handshake and staggers it so row i leaves i cycles after row 0, then drains and signals done.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data [ROWS],
  input  logic                  in_last,
  output logic [ROWS-1:0]       en_left,
  output logic [DATA_WIDTH-1:0] data_left [ROWS],
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [1:0]            dbg_state
);

  localparam int DCW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DCW-1:0]        r_drain_cnt;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;
  logic                  w_accept;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready; in_ready
  // depends only on state, and upstream must hold in_valid/in_data/in_last until it transfers.
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = in_last ? S_DRAIN : S_STREAM;
      S_STREAM: if (w_accept && in_last) w_next = S_DRAIN;
      S_DRAIN:  if (r_drain_cnt == '0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state != S_DRAIN);
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DRAIN) && (r_drain_cnt == '0);
    dbg_state = r_state;
  end

  // Counts the ROWS-1 cycles between the last beat leaving row 0 and leaving row ROWS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (w_accept && in_last) begin
      r_drain_cnt <= DCW'(ROWS - 1);
    end else if (r_state == S_DRAIN && r_drain_cnt != '0) begin
      r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_beat_cnt <= CNT_WIDTH'(1);
      end else if (r_beat_cnt != '1) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign beat_cnt = r_beat_cnt;

  // Row g owns g+1 stages; bubbles enter with zero data, so data_left is zero whenever en_left is.
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    logic [g:0]            r_en;
    logic [DATA_WIDTH-1:0] r_dat [g+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_en <= '0;
        for (int s = 0; s <= g; s++) r_dat[s] <= '0;
      end else begin
        r_en[0]  <= w_accept;
        r_dat[0] <= w_accept ? in_data[g] : '0;
        for (int s = 1; s <= g; s++) begin
          r_en[s]  <= r_en[s-1];
          r_dat[s] <= r_dat[s-1];
        end
      end
    end

    assign en_left[g]   = r_en[g];
    assign data_left[g] = r_dat[g];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder: a beat-level reference model feeds an expected
// queue, and a negedge monitor checks the skewed bus, done, busy, in_ready and beat_cnt.
`timescale 1ns/1ps
module tb_systolic_skew_feeder;

  localparam int DW   = 32;
  localparam int ROWS = 10;
  localparam int CW   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main DUT (ROWS=10) ----------------
  logic          in_valid, in_last, in_ready, busy, done;
  logic [DW-1:0] in_data [ROWS];
  logic [ROWS-1:0] en_left;
  logic [DW-1:0] data_left [ROWS];
  logic [CW-1:0] beat_cnt;
  logic [1:0]    dbg_state;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .en_left(en_left), .data_left(data_left), .busy(busy), .done(done),
    .beat_cnt(beat_cnt), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (ROWS=1) ----------------
  logic          r1_rst, r1_valid, r1_last, r1_ready, r1_busy, r1_done;
  logic [DW-1:0] r1_data [1];
  logic [0:0]    r1_en;
  logic [DW-1:0] r1_dl [1];
  logic [CW-1:0] r1_cnt;
  logic [1:0]    r1_state;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .ROWS(1), .CNT_WIDTH(CW)) dut_r1 (
    .clk(clk), .rst(r1_rst), .in_valid(r1_valid), .in_ready(r1_ready), .in_data(r1_data),
    .in_last(r1_last), .en_left(r1_en), .data_left(r1_dl), .busy(r1_busy), .done(r1_done),
    .beat_cnt(r1_cnt), .dbg_state(r1_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    int          row;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  bit   chk_en = 0;

  // Reference model state, valid for the current cycle `cyc`
  int            m_drain_end = -1;
  bit            m_busy = 0;
  logic [CW-1:0] m_cnt = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_evt(string name, int a, int e);
    n_vec++;
    n_fail++;
    $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, a, e);
  endtask

  // Beat-level model: an accept at cycle T shows row i at T+1+i; a last beat at T
  // closes the burst with done at T+ROWS and blocks input for cycles T+1..T+ROWS.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      done_q.delete();
      m_drain_end = -1;
      m_busy      = 0;
      m_cnt       = '0;
    end else if (in_valid && cyc > m_drain_end) begin
      for (int i = 0; i < ROWS; i++) begin
        e.cyc = cyc + 1 + i;
        e.row = i;
        e.d   = in_data[i];
        exp_q.push_back(e);
      end
      if (!m_busy) m_cnt = CW'(1);
      else if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      m_busy = 1;
      if (in_last) begin
        m_drain_end = cyc + ROWS;
        done_q.push_back(cyc + ROWS);
      end
    end else if (cyc == m_drain_end) begin
      m_busy = 0;
    end
    cyc    = cyc + 1;
    chk_en = 1;
  end

  // Monitor
  int mon_k;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, (cyc > m_drain_end));
      chk("busy", busy, m_busy);
      chk("beat_cnt", beat_cnt, m_cnt);
      if (done) begin
        if (done_q.size() == 0) fail_evt("done_unexpected", cyc, -1);
        else begin
          chk("done_cycle", done_q[0], cyc);
          void'(done_q.pop_front());
        end
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        fail_evt("done_missed", cyc, done_q[0]);
        void'(done_q.pop_front());
      end
      for (int i = 0; i < ROWS; i++) begin
        mon_k = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (exp_q[j].row == i) begin
            mon_k = j;
            break;
          end
        end
        if (en_left[i]) begin
          if (mon_k < 0) fail_evt("en_unexpected_row", i, -1);
          else begin
            chk("en_cycle", exp_q[mon_k].cyc, cyc);
            chk("data_left", data_left[i], exp_q[mon_k].d);
            exp_q.delete(mon_k);
          end
        end else begin
          chk("data_zero_when_idle", data_left[i], 0);
          if (mon_k >= 0 && exp_q[mon_k].cyc <= cyc) begin
            fail_evt("en_missed_row", i, exp_q[mon_k].cyc);
            exp_q.delete(mon_k);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < ROWS; i++) in_data[i] = $urandom;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_last  = 1'($urandom_range(0, 1));
      rand_data();
      tick();
    end
  endtask

  // Holds in_valid until the beat transfers (bounded).
  task automatic send(bit last);
    int budget;
    bit acc;
    budget   = 64;
    in_valid = 1'b1;
    in_last  = last;
    do begin
      acc = (cyc > m_drain_end);
      tick();
      budget--;
    end while (!acc && budget > 0);
    if (!acc) fail_evt("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] r1_v;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < ROWS; i++) in_data[i] = '0;
    r1_rst = 1'b1; r1_valid = 1'b0; r1_last = 1'b0; r1_data[0] = '0;
    repeat (3) tick();
    rst = 1'b0;
    idle(2);

    // single beat, data i+1
    for (int i = 0; i < ROWS; i++) in_data[i] = DW'(i + 1);
    send(1'b1);
    idle(ROWS + 2);

    // four back-to-back beats, value 16*beat+row
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < ROWS; i++) in_data[i] = DW'(16 * b + i);
      send(b == 3);
    end
    idle(ROWS + 2);

    // bubble between first and second beat
    rand_data(); send(1'b0);
    idle(1);
    rand_data(); send(1'b0);
    rand_data(); send(1'b1);
    idle(ROWS + 2);

    // second burst queued with in_valid held through drain
    rand_data(); send(1'b0);
    rand_data(); send(1'b1);
    for (int b = 0; b < 3; b++) begin
      rand_data(); send(b == 2);
    end
    idle(ROWS + 2);

    // reset three beats into a six-beat burst, then a fresh single beat
    for (int b = 0; b < 3; b++) begin
      rand_data(); send(1'b0);
    end
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b0; rand_data();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    idle(3);
    rand_data(); send(1'b1);
    idle(ROWS + 2);

    // random bursts with random bubbles and gaps
    repeat (25) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        rand_data();
        send(b == len - 1);
        if (b != len - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle($urandom_range(0, 3));
    end
    idle(ROWS + 3);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);

    // ROWS=1 instance: single last beat
    chk("r1_reset_en", r1_en, 0);
    chk("r1_reset_done", r1_done, 0);
    chk("r1_reset_busy", r1_busy, 0);
    chk("r1_reset_cnt", r1_cnt, 0);
    r1_rst = 1'b0;
    tick();
    r1_v       = $urandom;
    r1_data[0] = r1_v;
    r1_valid   = 1'b1;
    r1_last    = 1'b1;
    chk("r1_ready_idle", r1_ready, 1);
    tick();
    r1_valid = 1'b0;
    r1_last  = 1'b0;
    chk("r1_en_t1", r1_en, 1);
    chk("r1_data_t1", r1_dl[0], r1_v);
    chk("r1_done_t1", r1_done, 1);
    chk("r1_busy_t1", r1_busy, 1);
    chk("r1_ready_t1", r1_ready, 0);
    chk("r1_cnt_t1", r1_cnt, 1);
    tick();
    chk("r1_en_t2", r1_en, 0);
    chk("r1_data_t2", r1_dl[0], 0);
    chk("r1_done_t2", r1_done, 0);
    chk("r1_busy_t2", r1_busy, 0);
    chk("r1_state_idle_t2", r1_state, 0);
    chk("r1_ready_t2", r1_ready, 1);
    chk("r1_cnt_hold_t2", r1_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
